// File: rtl/instructions_pkg.sv
// Shared RV32 instruction encoding definitions: opcodes, funct codes, field
// positions and the decoded-instruction payload.
package instructions_pkg;

  localparam int unsigned RISCV_INST_W = 32;

  localparam int unsigned RISCV_INST_OPCODE_RANGE_LSB = 0;
  localparam int unsigned RISCV_INST_OPCODE_RANGE_W   = 7;
  localparam int unsigned RISCV_INST_RD_RANGE_LSB     = 7;
  localparam int unsigned RISCV_INST_RD_RANGE_W       = 5;
  localparam int unsigned RISCV_INST_FUNCT3_RANGE_LSB = 12;
  localparam int unsigned RISCV_INST_FUNCT3_RANGE_W   = 3;
  localparam int unsigned RISCV_INST_RS1_RANGE_LSB    = 15;
  localparam int unsigned RISCV_INST_RS1_RANGE_W      = 5;
  localparam int unsigned RISCV_INST_RS2_RANGE_LSB    = 20;
  localparam int unsigned RISCV_INST_RS2_RANGE_W      = 5;
  localparam int unsigned RISCV_INST_FUNCT7_RANGE_LSB = 25;
  localparam int unsigned RISCV_INST_FUNCT7_RANGE_W   = 7;

  typedef enum logic [6:0] {
    OPC_CUSTOM_0 = 7'b0001011,
    OPC_I        = 7'b0010011,
    OPC_U        = 7'b0010111,
    OPC_S        = 7'b0100011,
    OPC_R        = 7'b0110011,
    OPC_B        = 7'b1100011,
    OPC_J        = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } func3_s_type_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } func3_b_type_e;

  typedef enum logic [2:0] {
    F3_SLLI      = 3'b001,
    F3_SRLI_SRAI = 3'b101
  } func3_i_type_e;

  typedef enum logic [2:0] {
    F3_IDLE = 3'b000
  } func3_custom_e;

  // R-type funct3 values that accept the alternate funct7 (SUB, SRA).
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } decoded_inst_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: selects the format from the opcode and
// returns the sign-extended immediate (0 for R, custom_0 and unknown opcodes).
module riscv_imm_gen
  import instructions_pkg::*;
(
  input  logic [RISCV_INST_W-1:0] inst,
  output logic [31:0]             imm
);

  logic [6:0] opcode;

  assign opcode = inst[RISCV_INST_OPCODE_RANGE_LSB +: RISCV_INST_OPCODE_RANGE_W];

  always_comb begin
    imm = '0;
    case (opcode)
      OPC_I:   imm = {{20{inst[31]}}, inst[31:20]};
      OPC_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_U:   imm = {inst[31:12], 12'b0};
      OPC_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_inst_decoder.sv
// Two-stage RV32 instruction decoder on a valid/ready stream with legality
// checking and wrap-around delivered/illegal counters.
module riscv_inst_decoder
  import instructions_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [6:0]       dec_opcode,
  output logic [4:0]       dec_rd,
  output logic [4:0]       dec_rs1,
  output logic [4:0]       dec_rs2,
  output logic [2:0]       dec_funct3,
  output logic [6:0]       dec_funct7,
  output logic [31:0]      dec_imm,
  output logic             dec_illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic                    s1_valid_q, s1_valid_d;
  logic [RISCV_INST_W-1:0] s1_inst_q, s1_inst_d;
  logic                    s2_valid_q, s2_valid_d;
  decoded_inst_t           s2_q, s2_d;
  logic [CNT_W-1:0]        decoded_cnt_q, decoded_cnt_d;
  logic [CNT_W-1:0]        illegal_cnt_q, illegal_cnt_d;

  logic                    s1_ready_c, s2_ready_c;
  logic [31:0]             imm_c;
  decoded_inst_t           dec_c;
  logic [6:0]              op_c;
  logic [2:0]              f3_c;
  logic [6:0]              f7_c;
  logic                    legal_c;

  assign s2_ready_c = !s2_valid_q || dec_ready;
  assign s1_ready_c = !s1_valid_q || s2_ready_c;
  assign inst_ready = s1_ready_c;

  riscv_imm_gen u_imm_gen (
    .inst (s1_inst_q),
    .imm  (imm_c)
  );

  assign op_c = s1_inst_q[RISCV_INST_OPCODE_RANGE_LSB +: RISCV_INST_OPCODE_RANGE_W];
  assign f3_c = s1_inst_q[RISCV_INST_FUNCT3_RANGE_LSB +: RISCV_INST_FUNCT3_RANGE_W];
  assign f7_c = s1_inst_q[RISCV_INST_FUNCT7_RANGE_LSB +: RISCV_INST_FUNCT7_RANGE_W];

  // Field extraction and legality; unknown opcodes keep raw rd/rs1/funct3.
  always_comb begin
    dec_c        = '0;
    legal_c      = 1'b0;
    dec_c.opcode = op_c;
    dec_c.rd     = s1_inst_q[RISCV_INST_RD_RANGE_LSB +: RISCV_INST_RD_RANGE_W];
    dec_c.rs1    = s1_inst_q[RISCV_INST_RS1_RANGE_LSB +: RISCV_INST_RS1_RANGE_W];
    dec_c.funct3 = f3_c;
    case (op_c)
      OPC_R: begin
        dec_c.rs2    = s1_inst_q[RISCV_INST_RS2_RANGE_LSB +: RISCV_INST_RS2_RANGE_W];
        dec_c.funct7 = f7_c;
        legal_c      = (f7_c == FUNCT7_BASE) ||
                       ((f7_c == FUNCT7_ALT) && ((f3_c == F3_ADD_SUB) || (f3_c == F3_SRL_SRA)));
      end
      OPC_I: begin
        if (f3_c == F3_SLLI)           legal_c = (f7_c == FUNCT7_BASE);
        else if (f3_c == F3_SRLI_SRAI) legal_c = (f7_c == FUNCT7_BASE) || (f7_c == FUNCT7_ALT);
        else                           legal_c = 1'b1;
      end
      OPC_S: begin
        dec_c.rd  = '0;
        dec_c.rs2 = s1_inst_q[RISCV_INST_RS2_RANGE_LSB +: RISCV_INST_RS2_RANGE_W];
        legal_c   = (f3_c == F3_SB) || (f3_c == F3_SH) || (f3_c == F3_SW);
      end
      OPC_B: begin
        dec_c.rd  = '0;
        dec_c.rs2 = s1_inst_q[RISCV_INST_RS2_RANGE_LSB +: RISCV_INST_RS2_RANGE_W];
        legal_c   = (f3_c == F3_BEQ) || (f3_c == F3_BNE) || (f3_c == F3_BLT) ||
                    (f3_c == F3_BGE) || (f3_c == F3_BLTU) || (f3_c == F3_BGEU);
      end
      OPC_U, OPC_J: begin
        dec_c.rs1    = '0;
        dec_c.funct3 = '0;
        legal_c      = 1'b1;
      end
      OPC_CUSTOM_0: legal_c = (f3_c == F3_IDLE);
      default:      legal_c = 1'b0;
    endcase
    dec_c.illegal = !legal_c;
    dec_c.imm     = legal_c ? imm_c : '0;
  end

  // Stage advance and counters; clear takes priority over a delivery.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_inst_d     = s1_inst_q;
    s2_valid_d    = s2_valid_q;
    s2_d          = s2_q;
    decoded_cnt_d = decoded_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (s1_ready_c) begin
      s1_valid_d = inst_valid;
      if (inst_valid) s1_inst_d = inst;
    end
    if (s2_ready_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = dec_c;
    end
    if (cnt_clr) begin
      decoded_cnt_d = '0;
      illegal_cnt_d = '0;
    end else if (s2_valid_q && dec_ready) begin
      decoded_cnt_d = decoded_cnt_q + CNT_W'(1);
      if (s2_q.illegal) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_inst_q     <= '0;
      s2_valid_q    <= 1'b0;
      s2_q          <= '0;
      decoded_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_inst_q     <= s1_inst_d;
      s2_valid_q    <= s2_valid_d;
      s2_q          <= s2_d;
      decoded_cnt_q <= decoded_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign dec_valid   = s2_valid_q;
  assign dec_opcode  = s2_q.opcode;
  assign dec_rd      = s2_q.rd;
  assign dec_rs1     = s2_q.rs1;
  assign dec_rs2     = s2_q.rs2;
  assign dec_funct3  = s2_q.funct3;
  assign dec_funct7  = s2_q.funct7;
  assign dec_imm     = s2_q.imm;
  assign dec_illegal = s2_q.illegal;
  assign decoded_cnt = decoded_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_riscv_inst_decoder.sv
// Self-checking bench for riscv_inst_decoder: directed vectors plus random
// traffic scored against an arithmetic reference decoder.
module tb_riscv_inst_decoder;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inst_valid = 1'b0;
  logic             inst_ready;
  logic [31:0]      inst = '0;
  logic             dec_valid;
  logic             dec_ready = 1'b0;
  logic [6:0]       dec_opcode;
  logic [4:0]       dec_rd, dec_rs1, dec_rs2;
  logic [2:0]       dec_funct3;
  logic [6:0]       dec_funct7;
  logic [31:0]      dec_imm;
  logic             dec_illegal;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] decoded_cnt, illegal_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] sent_q[$];
  dec_t        got_q[$];
  int          got_cyc_q[$];

  riscv_inst_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_funct3(dec_funct3), .dec_funct7(dec_funct7), .dec_imm(dec_imm),
    .dec_illegal(dec_illegal), .cnt_clr(cnt_clr),
    .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Reference decoder built from the ISA bit layouts with plain arithmetic.
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    int unsigned op, f3, f7;
    int sw;
    bit is_r, is_i, is_s, is_b, is_u, is_j, is_c, legal;
    op = w & 32'h7F; f3 = (w >> 12) & 7; f7 = w >> 25;
    sw = $signed(w);
    is_r = (op == 51); is_i = (op == 19); is_s = (op == 35); is_b = (op == 99);
    is_u = (op == 23); is_j = (op == 111); is_c = (op == 11);
    d = '0;
    d.op  = 7'(op);
    d.rd  = (is_s || is_b) ? 5'd0 : 5'((w >> 7) & 31);
    d.rs1 = (is_u || is_j) ? 5'd0 : 5'((w >> 15) & 31);
    d.rs2 = (is_r || is_s || is_b) ? 5'((w >> 20) & 31) : 5'd0;
    d.f3  = (is_u || is_j) ? 3'd0 : 3'(f3);
    d.f7  = is_r ? 7'(f7) : 7'd0;
    if (is_r)      legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
    else if (is_i) legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
    else if (is_s) legal = (f3 <= 2);
    else if (is_b) legal = (f3 != 2) && (f3 != 3);
    else if (is_u || is_j) legal = 1'b1;
    else if (is_c) legal = (f3 == 0);
    else legal = 1'b0;
    if (is_i)      d.imm = 32'(sw >>> 20);
    else if (is_s) d.imm = 32'((sw >>> 25) * 32) + ((w >> 7) & 31);
    else if (is_b) d.imm = 32'((sw >>> 31) * 4096) + ((w >> 7) & 1) * 2048
                           + ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2;
    else if (is_u) d.imm = w & 32'hFFFFF000;
    else if (is_j) d.imm = 32'((sw >>> 31) * 1048576) + ((w >> 12) & 255) * 4096
                           + ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2;
    else d.imm = '0;
    if (!legal) d.imm = '0;
    d.ill = !legal;
    return d;
  endfunction

  function automatic dec_t cur();
    dec_t d;
    d = {dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal};
    return d;
  endfunction

  // One cycle: drive at the falling edge, log handshakes that the next rising edge takes.
  task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic clr);
    @(negedge clk);
    inst_valid = v; inst = w; dec_ready = rdy; cnt_clr = clr;
    cyc++;
    #1;
    if (rst_n && v && inst_ready) sent_q.push_back(w);
    if (rst_n && dec_valid && rdy) begin
      got_q.push_back(cur());
      got_cyc_q.push_back(cyc);
    end
  endtask

  task automatic drain(output bit timed_out);
    for (int k = 0; k < 64 && got_q.size() < sent_q.size(); k++) step(1'b0, '0, 1'b1, 1'b0);
    timed_out = (got_q.size() != sent_q.size());
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clear_logs();
    sent_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got=%b want=0", dec_valid); end
    checks++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL reset_inst_ready got=%b want=1", inst_ready); end
    checks++; if (cur() !== '0) begin errors++; $display("FAIL reset_fields got=%h want=0", cur()); end
    checks++; if ({decoded_cnt, illegal_cnt} !== '0) begin errors++;
      $display("FAIL reset_counters got=%h/%h want=0/0", decoded_cnt, illegal_cnt); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_addi();
    dec_t e;
    clear_logs();
    step(1'b1, 32'hFFF10093, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL addi_latency1 got=%b want=0", dec_valid); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL addi_latency2 got=%b want=1", dec_valid); end
    e = '0; e.op = 7'h13; e.rd = 5'd1; e.rs1 = 5'd2; e.imm = 32'hFFFFFFFF;
    checks++; if (cur() !== e) begin errors++; $display("FAIL addi_fields got=%h want=%h", cur(), e); end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_logs();
    step(1'b1, 32'h00532423, 1'b1, 1'b0);
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    drain(to);
    checks++; if (to || got_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d want=2", got_q.size()); end
    else begin
      checks++; if ({got_q[0].rs1, got_q[0].rs2, got_q[0].imm} !== {5'd6, 5'd5, 32'd8}) begin errors++;
        $display("FAIL sw_fields got=%0d/%0d/%h want=6/5/8", got_q[0].rs1, got_q[0].rs2, got_q[0].imm); end
      checks++; if (got_q[1].imm !== 32'hFFFFFFFC) begin errors++;
        $display("FAIL beq_imm got=%h want=fffffffc", got_q[1].imm); end
      checks++; if (got_cyc_q[1] - got_cyc_q[0] != 1) begin errors++;
        $display("FAIL b2b_spacing got=%0d want=1", got_cyc_q[1] - got_cyc_q[0]); end
    end
  endtask

  task automatic test_jal_auipc();
    bit to;
    clear_logs();
    step(1'b1, 32'h001000EF, 1'b1, 1'b0);
    step(1'b1, 32'h12345197, 1'b1, 1'b0);
    drain(to);
    checks++; if (to || got_q.size() != 2) begin errors++; $display("FAIL ju_count got=%0d want=2", got_q.size()); end
    else begin
      checks++; if ({got_q[0].rd, got_q[0].imm} !== {5'd1, 32'h00000800}) begin errors++;
        $display("FAIL jal_fields got=%0d/%h want=1/00000800", got_q[0].rd, got_q[0].imm); end
      checks++; if (got_q[1].imm !== 32'h12345000) begin errors++;
        $display("FAIL auipc_imm got=%h want=12345000", got_q[1].imm); end
    end
  endtask

  task automatic test_illegal();
    bit to;
    clear_logs();
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h00003023, 1'b1, 1'b0);
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    drain(to);
    checks++; if (to || got_q.size() != 2) begin errors++; $display("FAIL ill_count got=%0d want=2", got_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if ({got_q[i].ill, got_q[i].imm} !== {1'b1, 32'd0}) begin errors++;
        $display("FAIL ill_flag[%0d] got=%b/%h want=1/0", i, got_q[i].ill, got_q[i].imm); end
    end
    checks++; if ({decoded_cnt, illegal_cnt} !== {4'd2, 4'd2}) begin errors++;
      $display("FAIL ill_counters got=%0d/%0d want=2/2", decoded_cnt, illegal_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3];
    dec_t snap;
    bit to;
    clear_logs();
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    step(1'b1, w[0], 1'b0, 1'b0);
    step(1'b1, w[1], 1'b0, 1'b0);
    step(1'b1, w[2], 1'b0, 1'b0);
    snap = cur();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, w[2], 1'b0, 1'b0);
      checks++; if ({inst_ready, dec_valid} !== 2'b01) begin errors++;
        $display("FAIL bp_ready[%0d] got=%b/%b want=0/1", i, inst_ready, dec_valid); end
      checks++; if (cur() !== snap) begin errors++; $display("FAIL bp_stable[%0d] got=%h want=%h", i, cur(), snap); end
    end
    checks++; if (sent_q.size() != 2) begin errors++; $display("FAIL bp_accepted got=%0d want=2", sent_q.size()); end
    step(1'b1, w[2], 1'b1, 1'b0);
    drain(to);
    checks++; if (to || got_q.size() != 3) begin errors++; $display("FAIL bp_delivered got=%0d want=3", got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (got_q[i] !== ref_dec(w[i])) begin errors++;
        $display("FAIL bp_order[%0d] got=%h want=%h", i, got_q[i], ref_dec(w[i])); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    step(1'b1, 32'hFFF10093, 1'b1, 1'b0);
    step(1'b1, 32'h00532423, 1'b1, 1'b0);
    step(1'b1, 32'h001000EF, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dec_valid got=%b want=0", dec_valid); end
    checks++; if ({decoded_cnt, illegal_cnt} !== '0) begin errors++;
      $display("FAIL rstmid_counters got=%0d/%0d want=0/0", decoded_cnt, illegal_cnt); end
    step(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flushed got=%b want=0", dec_valid); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int n_ill;
    bit to;
    clear_logs();
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      case ($urandom_range(0, 7))
        0: w[6:0] = 7'h33; 1: w[6:0] = 7'h13; 2: w[6:0] = 7'h23; 3: w[6:0] = 7'h63;
        4: w[6:0] = 7'h17; 5: w[6:0] = 7'h6F; 6: w[6:0] = 7'h0B; default: ;
      endcase
      case ($urandom_range(0, 2))
        0: w[31:25] = 7'h00; 1: w[31:25] = 7'h20; default: ;
      endcase
      step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL rnd_drain got=%0d want=%0d", got_q.size(), sent_q.size()); end
    n_ill = 0;
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) begin
      if (ref_dec(sent_q[i]).ill) n_ill++;
      checks++; if (got_q[i] !== ref_dec(sent_q[i])) begin errors++;
        $display("FAIL rnd_word[%0d] inst=%h got=%h want=%h", i, sent_q[i], got_q[i], ref_dec(sent_q[i])); end
    end
    checks++; if (decoded_cnt !== CNT_W'(got_q.size() % 16)) begin errors++;
      $display("FAIL rnd_decoded_cnt got=%0d want=%0d", decoded_cnt, got_q.size() % 16); end
    checks++; if (illegal_cnt !== CNT_W'(n_ill % 16)) begin errors++;
      $display("FAIL rnd_illegal_cnt got=%0d want=%0d", illegal_cnt, n_ill % 16); end
  endtask

  task automatic test_counter_wrap();
    bit to;
    clear_logs();
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 32'h00000013 + 32'(i << 7), 1'b1, 1'b0);
    drain(to);
    checks++; if (to || decoded_cnt !== 4'd0 || got_q.size() != 16) begin errors++;
      $display("FAIL wrap_cnt got=%0d (delivered %0d) want=0 (16)", decoded_cnt, got_q.size()); end
    clear_logs();
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    step(1'b1, 32'h00100093, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL clr_delivered got=%0d want=2", got_q.size()); end
    checks++; if ({decoded_cnt, illegal_cnt} !== '0) begin errors++;
      $display("FAIL clr_wins got=%0d/%0d want=0/0", decoded_cnt, illegal_cnt); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jal_auipc();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_inst_decoder.md
Name: riscv_inst_decoder

Overview:
Pipelined RV32 instruction decoder and the decode-side counterpart of the shared instruction encoding package. Accepts raw 32-bit instruction words on a valid/ready stream and emits decoded fields plus a sign-extended immediate. Flags encodings outside the supported subset as illegal. Sits between the instruction stimulus/fetch path and the reference model/scoreboard, and keeps running decode and illegal-instruction counts.

Parameters:
CNT_W, 16, width of the decoded-instruction and illegal-instruction counters (wrap-around).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  input word valid
inst_ready  out  1  decoder can accept a word
inst  in  32  raw instruction word
dec_valid  out  1  decoded result valid
dec_ready  in  1  consumer accepts result
dec_opcode  out  7  opcode field, inst[6:0]
dec_rd  out  5  inst[11:7]; 0 for S/B types
dec_rs1  out  5  inst[19:15]; 0 for U/J types
dec_rs2  out  5  inst[24:20]; 0 unless R/S/B type
dec_funct3  out  3  inst[14:12]; 0 for U/J types
dec_funct7  out  7  inst[31:25] for R-type, else 0
dec_imm  out  32  sign-extended immediate per format
dec_illegal  out  1  unsupported encoding
cnt_clr  in  1  synchronous clear of both counters
decoded_cnt  out  CNT_W  words delivered on the dec handshake
illegal_cnt  out  CNT_W  delivered words with dec_illegal=1

Behaviour:
- Reset values: all outputs 0; inst_ready=1 after reset; both stage-valid flags cleared.
- Two register stages.
  - S1 captures inst on inst_valid && inst_ready.
  - S2 holds the decoded fields.
  - Latency is 2 cycles from input handshake to dec_valid when dec_ready stays 1.
  - Throughput is 1 word/cycle.
- Stage ready rules:
  - s2_ready = !s2_valid || dec_ready.
  - s1_ready = !s1_valid || s2_ready.
  - inst_ready = s1_ready. The combinational ready chain is permitted.
- Backpressure: while dec_valid && !dec_ready, all dec_* outputs hold stable. A word is never dropped or duplicated.
- Simultaneous input and output handshakes in the same cycle are both honoured; the pipeline stays full.
- Immediates, all sign-extended from the top bit:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - U (AUIPC): {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - R and custom_0: 0.
- Legality rules (any violation sets dec_illegal=1):
  - opcode must be one of r, i, s, b, u, j, custom_0; any other opcode is illegal.
  - R: funct7=0000000 with any funct3, or funct7=0100000 with funct3 000 or 101.
  - I, slli (funct3 001): inst[31:25]=0000000.
  - I, srli_srai (funct3 101): inst[31:25] is 0000000 or 0100000.
  - I, other funct3: always legal.
  - S: funct3 must be sb, sh or sw.
  - B: funct3 010 and 011 are illegal.
  - custom_0: funct3 must be idle (000).
- Illegal words: still delivered with raw fields decoded; dec_imm=0.
- Counters:
  - Both increment on the dec_valid && dec_ready handshake; illegal_cnt only when dec_illegal=1.
  - Both wrap from all-ones to 0.
  - cnt_clr wins over a same-cycle increment.
- Reset asserted mid-operation: in-flight words are discarded, dec_valid drops asynchronously, counters go to 0.

Decomposition:
- Add to instructions_pkg:
  - func3_b_type_e (beq=000, bne=001, blt=100, bge=101, bltu=110, bgeu=111).
  - funct7 constants FUNCT7_BASE=7'b0000000 and FUNCT7_ALT=7'b0100000.
  - A decoded_inst_t packed struct grouping opcode, rd, rs1, rs2, funct3, funct7, imm and illegal.
  - Use the existing RISCV_INST_*_RANGE constants for field slicing.
- One sub-module: riscv_imm_gen, a purely combinational format-to-immediate generator instantiated between S1 and S2.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093) -> after 2 cycles dec_rd=1, dec_rs1=2, dec_funct3=0, dec_imm=0xFFFFFFFF, dec_illegal=0.
- SW x5,8(x6) (0x00532423), then BEQ x0,x0,-4 (0xFE000EE3), back-to-back:
  - SW -> dec_rs1=6, dec_rs2=5, dec_imm=8.
  - BEQ -> dec_imm=0xFFFFFFFC.
  - Both delivered on consecutive cycles.
- JAL x1,2048 (0x001000EF) -> dec_rd=1, dec_imm=0x00000800. AUIPC x3,0x12345 (0x12345197) -> dec_imm=0x12345000.
- Illegal words 0x00003023 (store funct3 011) and 0x0000007F (bad opcode) -> dec_illegal=1, dec_imm=0; illegal_cnt=2, decoded_cnt=2.
- Backpressure and reset:
  - Hold dec_ready=0 with 3 words offered -> only 2 accepted, inst_ready=0, dec_* stable.
  - Release dec_ready -> words emerge in order.
  - Assert rst_n=0 mid-burst -> dec_valid=0 immediately, counters=0.
- Counter wrap with CNT_W=4: after 16 delivered words decoded_cnt=0. cnt_clr coincident with a delivery -> decoded_cnt=0.
